// File: rtl/binary_frame_ctrl.sv
// binary_frame_ctrl: arms on a start request, captures one binarized frame
// (skin-pixel count and bounding box), then holds the result until it is
// acknowledged. Also owns the binarizer grey-window thresholds, which only
// change at the start of a captured frame so a frame never sees a mixed setting.
module binary_frame_ctrl #(
  parameter int CNT_W = 24
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic             iFrame_En,
  input  logic             iDVAL,
  input  logic             iBinary,
  input  logic [15:0]      iX_Cont,
  input  logic [15:0]      iY_Cont,
  input  logic             iCfg_WE,
  input  logic [11:0]      iCfg_Lo,
  input  logic [11:0]      iCfg_Hi,
  output logic [11:0]      oThr_Lo,
  output logic [11:0]      oThr_Hi,
  output logic             oBusy,
  output logic             oRes_Valid,
  input  logic             iRes_Ack,
  output logic [CNT_W-1:0] oCount,
  output logic [15:0]      oXmin,
  output logic [15:0]      oXmax,
  output logic [15:0]      oYmin,
  output logic [15:0]      oYmax,
  output logic [7:0]       oFrames,
  output logic [1:0]       oState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_CAP  = 2'd2,
    S_REP  = 2'd3
  } state_t;

  localparam logic [11:0]      THR_LO_RST = 12'd205;
  localparam logic [11:0]      THR_HI_RST = 12'd255;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      MIN_INIT   = 16'hFFFF;
  localparam logic [15:0]      MAX_INIT   = 16'h0000;

  state_t           state_q, state_d;
  logic             fe_q, fe_d;
  logic [11:0]      pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
  logic [11:0]      thr_lo_q, thr_lo_d, thr_hi_q, thr_hi_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      xmin_q, xmin_d, xmax_q, xmax_d;
  logic [15:0]      ymin_q, ymin_d, ymax_q, ymax_d;
  logic [7:0]       frames_q, frames_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic             rise_s, fall_s, load_s, pix_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [15:0]      xmin_base_s, xmax_base_s, ymin_base_s, ymax_base_s;

  assign rise_s = iFrame_En & ~fe_q;
  assign fall_s = ~iFrame_En & fe_q;
  // The rise seen while armed both starts the frame and may carry its first pixel.
  assign load_s = (state_q == S_ARM) & rise_s;
  assign pix_s  = ((state_q == S_CAP) | load_s) & iFrame_En & iDVAL & iBinary;

  // Frame sequencing, threshold handover, result flag and report counter.
  always_comb begin
    state_d     = state_q;
    fe_d        = iFrame_En;
    thr_lo_d    = thr_lo_q;
    thr_hi_d    = thr_hi_q;
    res_valid_d = res_valid_q;
    frames_d    = frames_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (rise_s) begin
          state_d  = S_CAP;
          // Pending value before any same-cycle write is what the frame uses.
          thr_lo_d = pend_lo_q;
          thr_hi_d = pend_hi_q;
        end else begin
          state_d = S_ARM;
        end
      end
      S_CAP: begin
        if (fall_s) begin
          state_d     = S_REP;
          res_valid_d = 1'b1;
        end else begin
          state_d = S_CAP;
        end
      end
      S_REP: begin
        if (iRes_Ack) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          frames_d    = frames_q + 8'd1;
        end else begin
          state_d = S_REP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Pending threshold registers accept writes in any state.
  always_comb begin
    if (iCfg_WE) begin
      pend_lo_d = iCfg_Lo;
      pend_hi_d = iCfg_Hi;
    end else begin
      pend_lo_d = pend_lo_q;
      pend_hi_d = pend_hi_q;
    end
  end

  // Accumulators: restart from init on the frame rise, then fold in counted pixels.
  always_comb begin
    if (load_s) begin
      cnt_base_s  = {CNT_W{1'b0}};
      xmin_base_s = MIN_INIT;
      xmax_base_s = MAX_INIT;
      ymin_base_s = MIN_INIT;
      ymax_base_s = MAX_INIT;
    end else begin
      cnt_base_s  = count_q;
      xmin_base_s = xmin_q;
      xmax_base_s = xmax_q;
      ymin_base_s = ymin_q;
      ymax_base_s = ymax_q;
    end
    if (pix_s) begin
      count_d = (cnt_base_s == CNT_MAX) ? cnt_base_s : (cnt_base_s + CNT_ONE);
      xmin_d  = (iX_Cont < xmin_base_s) ? iX_Cont : xmin_base_s;
      xmax_d  = (iX_Cont > xmax_base_s) ? iX_Cont : xmax_base_s;
      ymin_d  = (iY_Cont < ymin_base_s) ? iY_Cont : ymin_base_s;
      ymax_d  = (iY_Cont > ymax_base_s) ? iY_Cont : ymax_base_s;
    end else begin
      count_d = cnt_base_s;
      xmin_d  = xmin_base_s;
      xmax_d  = xmax_base_s;
      ymin_d  = ymin_base_s;
      ymax_d  = ymax_base_s;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      fe_q        <= 1'b0;
      pend_lo_q   <= THR_LO_RST;
      pend_hi_q   <= THR_HI_RST;
      thr_lo_q    <= THR_LO_RST;
      thr_hi_q    <= THR_HI_RST;
      count_q     <= {CNT_W{1'b0}};
      xmin_q      <= MIN_INIT;
      xmax_q      <= MAX_INIT;
      ymin_q      <= MIN_INIT;
      ymax_q      <= MAX_INIT;
      frames_q    <= 8'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fe_q        <= fe_d;
      pend_lo_q   <= pend_lo_d;
      pend_hi_q   <= pend_hi_d;
      thr_lo_q    <= thr_lo_d;
      thr_hi_q    <= thr_hi_d;
      count_q     <= count_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      frames_q    <= frames_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign oThr_Lo    = thr_lo_q;
  assign oThr_Hi    = thr_hi_q;
  assign oBusy      = busy_q;
  assign oRes_Valid = res_valid_q;
  assign oCount     = count_q;
  assign oXmin      = xmin_q;
  assign oXmax      = xmax_q;
  assign oYmin      = ymin_q;
  assign oYmax      = ymax_q;
  assign oFrames    = frames_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_binary_frame_ctrl.sv
// Bench for binary_frame_ctrl: directed table, hand sequences for the
// multi-cycle corners, and random traffic, all checked every cycle against a
// frame-level reference model (pixel list per frame, results derived from it).
module tb_binary_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, fe, dval, bin, we, ack;
  logic [15:0] x, y;
  logic [11:0] clo, chi;

  logic [11:0] thr_lo, thr_hi;
  logic        busy, valid;
  logic [23:0] count;
  logic [15:0] xmin, xmax, ymin, ymax;
  logic [7:0]  frames;
  logic [1:0]  st;

  logic [11:0] thr_lo4, thr_hi4;
  logic        busy4, valid4;
  logic [3:0]  count4;
  logic [15:0] xmin4, xmax4, ymin4, ymax4;
  logic [7:0]  frames4;
  logic [1:0]  st4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  binary_frame_ctrl dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iFrame_En(fe), .iDVAL(dval),
    .iBinary(bin), .iX_Cont(x), .iY_Cont(y), .iCfg_WE(we), .iCfg_Lo(clo),
    .iCfg_Hi(chi), .oThr_Lo(thr_lo), .oThr_Hi(thr_hi), .oBusy(busy),
    .oRes_Valid(valid), .iRes_Ack(ack), .oCount(count), .oXmin(xmin),
    .oXmax(xmax), .oYmin(ymin), .oYmax(ymax), .oFrames(frames), .oState(st)
  );

  binary_frame_ctrl #(.CNT_W(4)) dut4 (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iFrame_En(fe), .iDVAL(dval),
    .iBinary(bin), .iX_Cont(x), .iY_Cont(y), .iCfg_WE(we), .iCfg_Lo(clo),
    .iCfg_Hi(chi), .oThr_Lo(thr_lo4), .oThr_Hi(thr_hi4), .oBusy(busy4),
    .oRes_Valid(valid4), .iRes_Ack(ack), .oCount(count4), .oXmin(xmin4),
    .oXmax(xmax4), .oYmin(ymin4), .oYmax(ymax4), .oFrames(frames4), .oState(st4)
  );

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 waiting for frame start, 2 in frame, 3 result held.
  int m_phase, m_fe, m_plo, m_phi, m_tlo, m_thi, m_frames, m_valid;
  int qx[$];
  int qy[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    bit rise, fall, pix;
    rise = fe && (m_fe == 0);
    fall = !fe && (m_fe == 1);
    pix  = fe && dval && bin;
    if (!rst_n) begin
      m_phase = 0; m_fe = 0; m_plo = 205; m_phi = 255; m_tlo = 205; m_thi = 255;
      m_frames = 0; m_valid = 0;
      qx.delete(); qy.delete();
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (rise) begin
             m_phase = 2; m_tlo = m_plo; m_thi = m_phi;
             qx.delete(); qy.delete();
             if (pix) begin qx.push_back(int'(x)); qy.push_back(int'(y)); end
           end
        2: if (fall) begin
             m_phase = 3; m_valid = 1;
           end else if (pix) begin
             qx.push_back(int'(x)); qy.push_back(int'(y));
           end
        3: if (ack) begin
             m_phase = 0; m_valid = 0; m_frames = (m_frames + 1) % 256;
           end
        default: m_phase = 0;
      endcase
      if (we) begin m_plo = int'(clo); m_phi = int'(chi); end
      m_fe = fe ? 1 : 0;
    end
  endfunction

  // Results come straight from the list of counted pixels of the last frame.
  function automatic void check_all();
    int n, exmin, exmax, eymin, eymax;
    n = qx.size();
    exmin = 65535; exmax = 0; eymin = 65535; eymax = 0;
    foreach (qx[i]) begin
      if (qx[i] < exmin) exmin = qx[i];
      if (qx[i] > exmax) exmax = qx[i];
      if (qy[i] < eymin) eymin = qy[i];
      if (qy[i] > eymax) eymax = qy[i];
    end
    chk("state", st, m_phase);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("res_valid", valid, m_valid);
    chk("count", count, (n > 24'hFFFFFF) ? 24'hFFFFFF : n);
    chk("count_w4", count4, (n > 15) ? 15 : n);
    chk("xmin", xmin, exmin);
    chk("xmax", xmax, exmax);
    chk("ymin", ymin, eymin);
    chk("ymax", ymax, eymax);
    chk("frames", frames, m_frames);
    chk("thr_lo", thr_lo, m_tlo);
    chk("thr_hi", thr_hi, m_thi);
  endfunction

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    start = 1'b0; fe = 1'b0; dval = 1'b0; bin = 1'b0; we = 1'b0; ack = 1'b0;
    x = 16'd0; y = 16'd0;
  endtask

  task automatic do_frame(int w, int h, bit skin);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        fe = 1'b1; dval = 1'b1; bin = skin; x = 16'(i); y = 16'(j);
        step();
      end
    end
    fe = 1'b0; dval = 1'b0; bin = 1'b0;
    step();
  endtask

  task automatic arm();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic acknowledge();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        start, fe, dval, bin;
    logic [15:0] x, y;
    logic        ack;
    logic [1:0]  e_st;
    logic        e_v;
    logic [23:0] e_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mkv(logic s, logic f, logic d, logic b, int xx, int yy,
                               logic a, int es, logic ev, int ec);
    vec_t v;
    v.start = s; v.fe = f; v.dval = d; v.bin = b; v.x = 16'(xx); v.y = 16'(yy);
    v.ack = a; v.e_st = 2'(es); v.e_v = ev; v.e_cnt = 24'(ec);
    return v;
  endfunction

  int exp_f;

  initial begin
    // 4x4 frame, skin at (1,1), (2,1), (2,3); expected state/valid/count after each edge.
    tbl[0] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tbl[2+i] = mkv(0, 1, 1, (i == 5 || i == 6 || i == 14), i % 4, i / 4, 0, 2, 0,
                     (i < 5) ? 0 : (i < 6) ? 1 : (i < 14) ? 2 : 3);
    end
    tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 3, 1, 3);
    tbl[19] = mkv(0, 0, 0, 0, 0, 0, 0, 3, 1, 3);
    tbl[20] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);

    quiet(); clo = 12'd0; chi = 12'd0;
    rst_n = 1'b0;
    step(); step();
    chk("rst_state", st, 0);
    chk("rst_thr_lo", thr_lo, 205);
    chk("rst_thr_hi", thr_hi, 255);
    chk("rst_xmin", xmin, 16'hFFFF);
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    step();

    // Basic frame from the table.
    for (int k = 0; k < 21; k++) begin
      start = tbl[k].start; fe = tbl[k].fe; dval = tbl[k].dval; bin = tbl[k].bin;
      x = tbl[k].x; y = tbl[k].y; ack = tbl[k].ack;
      step();
      chk("tbl_state", st, tbl[k].e_st);
      chk("tbl_valid", valid, tbl[k].e_v);
      chk("tbl_count", count, tbl[k].e_cnt);
    end
    quiet();
    chk("basic_xmin", xmin, 1); chk("basic_xmax", xmax, 2);
    chk("basic_ymin", ymin, 1); chk("basic_ymax", ymax, 3);
    chk("basic_frames", frames, 1);

    // Partial frame: start while the frame is already active.
    fe = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dval = 1'b1; bin = 1'b1; x = 16'd7; y = 16'd7; step();
    end
    chk("partial_state", st, 1);
    chk("partial_hold_count", count, 3);
    fe = 1'b0; dval = 1'b0; bin = 1'b0; step();
    chk("partial_fall_arm", st, 1);
    fe = 1'b1; dval = 1'b1;
    bin = 1'b0; x = 16'd4; y = 16'd4; step();
    bin = 1'b1; x = 16'd5; y = 16'd6; step();
    bin = 1'b0; x = 16'd9; y = 16'd9; step();
    fe = 1'b0; dval = 1'b0; step();
    chk("partial_count", count, 1);
    chk("partial_xmin", xmin, 5);
    chk("partial_ymax", ymax, 6);
    acknowledge();

    // Threshold write during capture only lands on the next frame's rise.
    arm();
    fe = 1'b1; dval = 1'b1; bin = 1'b0; step();
    we = 1'b1; clo = 12'd100; chi = 12'd200; step(); we = 1'b0;
    step();
    chk("thr_cap_lo", thr_lo, 205);
    fe = 1'b0; dval = 1'b0; step();
    acknowledge();
    chk("thr_idle_hi", thr_hi, 255);
    arm();
    fe = 1'b1; dval = 1'b1; we = 1'b1; clo = 12'd50; chi = 12'd60; step(); we = 1'b0;
    chk("thr_rise_lo", thr_lo, 100);
    chk("thr_rise_hi", thr_hi, 200);
    step();
    fe = 1'b0; dval = 1'b0; step();
    acknowledge();

    // Empty frame, long hold without acknowledge.
    arm();
    do_frame(3, 3, 1'b0);
    chk("empty_count", count, 0);
    chk("empty_xmin", xmin, 16'hFFFF);
    chk("empty_xmax", xmax, 0);
    exp_f = m_frames;
    for (int i = 0; i < 50; i++) begin
      start = 1'($urandom); fe = 1'($urandom); dval = 1'($urandom); bin = 1'($urandom);
      x = 16'($urandom); y = 16'($urandom);
      step();
    end
    quiet();
    chk("hold_valid", valid, 1);
    chk("hold_ymin", ymin, 16'hFFFF);
    acknowledge();
    chk("ack_state", st, 0);
    chk("ack_frames", frames, (exp_f + 1) % 256);
    step();
    chk("ack_valid_low", valid, 0);

    // Saturation on the narrow counter.
    arm();
    do_frame(5, 4, 1'b1);
    chk("sat_count4", count4, 15);
    chk("sat_count24", count, 20);
    acknowledge();

    // Reset in the middle of a frame.
    arm();
    fe = 1'b1; dval = 1'b1; bin = 1'b1;
    for (int i = 0; i < 3; i++) begin x = 16'(i); step(); end
    chk("mid_state_cap", st, 2);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_state", st, 0);
    chk("mid_rst_thr_lo", thr_lo, 205);
    chk("mid_rst_thr_hi", thr_hi, 255);
    chk("mid_rst_count", count, 0);
    for (int i = 0; i < 3; i++) step();
    fe = 1'b0; step(); step();
    chk("mid_no_valid", valid, 0);
    chk("mid_idle", st, 0);
    quiet();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      we    = ($urandom_range(0, 9) == 0);
      clo   = 12'($urandom); chi = 12'($urandom);
      if ($urandom_range(0, 9) == 0) fe = ~fe;
      dval  = 1'($urandom); bin = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        x = 16'($urandom); y = 16'($urandom);
      end else begin
        x = 16'($urandom_range(100, 200)); y = 16'($urandom_range(50, 90));
      end
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
